// File: rtl/fizzbuzz_formatter.sv
// Formats one classified fizzbuzz item per handshake as an ASCII line on a
// byte stream: "Fizz", "Buzz", "FizzBuzz" or the decimal value, then EOL.
module fizzbuzz_formatter #(
  parameter int          WIDTH  = 32,
  parameter int          DIGITS = 10,
  parameter logic [7:0]  EOL    = 8'h0A
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] number,
  input  logic             print_number,
  input  logic             print_fizz,
  input  logic             print_buzz,
  input  logic             print_fizzbuzz,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_char,
  output logic             out_last,
  output logic             busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_EMIT = 2'd2;

  localparam logic [1:0] M_NUM  = 2'd0;
  localparam logic [1:0] M_FIZZ = 2'd1;
  localparam logic [1:0] M_BUZZ = 2'd2;
  localparam logic [1:0] M_FB   = 2'd3;

  localparam int BW = DIGITS * 4;
  // Byte position must reach the EOL slot of the longest line (digits or "FizzBuzz").
  localparam int PW = $clog2(((DIGITS > 8) ? DIGITS : 8) + 1);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [1:0]       state;
  logic [1:0]       mode;
  logic [BW-1:0]    bcd;
  logic [BW-1:0]    bcd_adj;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic [PW-1:0]    pos;
  logic [PW-1:0]    msd;
  logic [PW-1:0]    len;
  logic [PW-1:0]    dig_sel;
  logic [3:0]       nib;
  logic [7:0]       word_char;
  logic             at_eol;

  function automatic logic [7:0] fizz_char(input logic [1:0] k);
    case (k)
      2'd0:    return 8'h46;
      2'd1:    return 8'h69;
      default: return 8'h7A;
    endcase
  endfunction

  function automatic logic [7:0] buzz_char(input logic [1:0] k);
    case (k)
      2'd0:    return 8'h42;
      2'd1:    return 8'h75;
      default: return 8'h7A;
    endcase
  endfunction

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
  end

  // Highest non-zero digit sets the line length; an all-zero value still prints "0".
  always_comb begin
    msd = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[i*4 +: 4] != 4'd0) msd = PW'(i);
    end
  end

  always_comb begin
    dig_sel = msd - pos;
    nib     = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_sel == PW'(i)) nib = bcd[i*4 +: 4];
    end
  end

  always_comb begin
    case (mode)
      M_FIZZ:  word_char = fizz_char(pos[1:0]);
      M_BUZZ:  word_char = buzz_char(pos[1:0]);
      M_FB:    word_char = pos[2] ? buzz_char(pos[1:0]) : fizz_char(pos[1:0]);
      default: word_char = 8'h00;
    endcase
  end

  always_comb begin
    case (mode)
      M_NUM:   len = msd + PW'(1);
      M_FB:    len = PW'(8);
      default: len = PW'(4);
    endcase
  end

  assign at_eol    = (pos == len);
  assign in_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign out_valid = (state == S_EMIT);
  assign out_last  = out_valid && at_eol;

  always_comb begin
    if (!out_valid)        out_char = 8'h00;
    else if (at_eol)       out_char = EOL;
    else if (mode == M_NUM) out_char = 8'h30 + {4'h0, nib};
    else                   out_char = word_char;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      mode  <= M_NUM;
      bcd   <= '0;
      shreg <= '0;
      cnt   <= '0;
      pos   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            bcd   <= '0;
            shreg <= number;
            cnt   <= '0;
            pos   <= '0;
            if (print_fizzbuzz) begin
              mode  <= M_FB;
              state <= S_EMIT;
            end else if (print_fizz) begin
              mode  <= M_FIZZ;
              state <= S_EMIT;
            end else if (print_buzz) begin
              mode  <= M_BUZZ;
              state <= S_EMIT;
            end else begin
              mode  <= M_NUM;
              state <= S_CONV;
            end
          end
        end
        S_CONV: begin
          bcd   <= {bcd_adj[BW-2:0], shreg[WIDTH-1]};
          shreg <= shreg << 1;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) state <= S_EMIT;
        end
        S_EMIT: begin
          if (out_ready) begin
            if (at_eol) begin
              state <= S_IDLE;
              pos   <= '0;
            end else begin
              pos <= pos + PW'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fizzbuzz_formatter.sv
// Directed bench for fizzbuzz_formatter: line contents, latency, stalls, reset.
module tb_fizzbuzz_formatter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] number;
  logic        print_number;
  logic        print_fizz;
  logic        print_buzz;
  logic        print_fizzbuzz;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_char;
  logic        out_last;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fizzbuzz_formatter dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .number(number),
    .print_number(print_number), .print_fizz(print_fizz),
    .print_buzz(print_buzz), .print_fizzbuzz(print_fizzbuzz),
    .out_valid(out_valid), .out_ready(out_ready), .out_char(out_char),
    .out_last(out_last), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // flags = {fizzbuzz, fizz, buzz, number}; exp excludes the EOL byte
  task automatic run_line(input string tag, input logic [31:0] num, input logic [3:0] flags,
                          input string exp, input int lat_exp, input bit toggle);
    int  lat;
    int  idx;
    int  k;
    bit  seen;
    string line;
    line = {exp, "\n"};
    @(negedge clk);
    check({tag, "_in_ready_pre"}, in_ready, 1);
    in_valid  = 1'b1;
    number    = num;
    {print_fizzbuzz, print_fizz, print_buzz, print_number} = flags;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    {print_fizzbuzz, print_fizz, print_buzz, print_number} = 4'b0000;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 200) begin
      @(negedge clk);
      lat++;
      if (out_valid) seen = 1'b1;
    end
    check({tag, "_latency"}, lat, lat_exp);
    if (!seen) return;
    idx = 0;
    k   = 0;
    while (idx < line.len() && k < 100) begin
      out_ready = toggle ? (k % 2 == 0) : 1'b1;
      check($sformatf("%s_valid%0d", tag, idx), out_valid, 1);
      check($sformatf("%s_char%0d", tag, idx), out_char, line[idx]);
      check($sformatf("%s_last%0d", tag, idx), out_last, (idx == line.len() - 1));
      check($sformatf("%s_in_ready_busy%0d", tag, idx), in_ready, 0);
      @(posedge clk);
      if (out_ready) idx++;
      k++;
      @(negedge clk);
    end
    check({tag, "_done"}, idx, line.len());
    check({tag, "_in_ready_post"}, in_ready, 1);
    check({tag, "_valid_post"}, out_valid, 0);
    out_ready = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    number = '0;
    {print_fizzbuzz, print_fizz, print_buzz, print_number} = 4'b0000;
    out_ready = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_char", out_char, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_line("num7",    32'd7,          4'b0001, "7",          33, 1'b0);
    run_line("fizz3",   32'd3,          4'b0100, "Fizz",       1,  1'b0);
    run_line("fb15",    32'd15,         4'b1111, "FizzBuzz",   1,  1'b0);
    run_line("num0",    32'd0,          4'b0001, "0",          33, 1'b0);
    run_line("nummax",  32'hFFFFFFFF,   4'b0001, "4294967295", 33, 1'b0);
    run_line("noflag",  32'd1000000,    4'b0000, "1000000",    33, 1'b0);
    run_line("buzz",    32'd5,          4'b0010, "Buzz",       1,  1'b1);
    run_line("fizzbz",  32'd9,          4'b0110, "Fizz",       1,  1'b0);

    // Reset in the middle of a line after the 'F' handshake
    @(negedge clk);
    in_valid = 1'b1;
    number = 32'd6;
    print_fizz = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    print_fizz = 1'b0;
    @(negedge clk);
    check("mid_first_char", out_char, 8'h46);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_char", out_char, 0);
    check("mid_rst_last", out_last, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("post_rst_quiet%0d", i), out_valid, 0);
      check($sformatf("post_rst_ready%0d", i), in_ready, 1);
    end
    run_line("num100", 32'd100, 4'b0001, "100", 33, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
